// File: rtl/if_id_buffer_pkg.sv
// Shared MIPS instruction-field layout, opcode constants and the IF/ID entry type
// used by the fetch-to-decode buffer.
package if_id_buffer_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W_DEF  = 32;
  localparam int OPC_MSB   = 31;
  localparam int RS_MSB    = 25;
  localparam int RT_MSB    = 20;
  localparam int RD_MSB    = 15;
  localparam int SHAMT_MSB = 10;
  localparam int IMM_W     = 16;
  localparam int OPC_W     = 6;
  localparam int REG_W     = 5;
  localparam int FUNCT_W   = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo.sv
// Circular-buffer storage for the IF/ID stage: pointers, occupancy count and
// synchronous flush. Callers must not push when full or pop when empty.
module if_id_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              wr_en_s;

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == CNT_W'(0));

  // Next-state for pointers and count; flush outranks push and pop.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    wr_en_s      = 1'b0;
    if (flush) begin
      rd_ptr_nxt_s = PTR_W'(0);
      wr_ptr_nxt_s = PTR_W'(0);
      count_nxt_s  = CNT_W'(0);
    end else begin
      if (push) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        wr_en_s      = 1'b1;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= PTR_W'(0);
      wr_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Entry storage; cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: valid/ready handshake around a small FIFO of (pc, instr)
// pairs, with the head instruction sliced into MIPS fields for decode.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [OPC_W-1:0]         out_opcode,
  output logic [REG_W-1:0]         out_rs,
  output logic [REG_W-1:0]         out_rt,
  output logic [REG_W-1:0]         out_rd,
  output logic [REG_W-1:0]         out_shamt,
  output logic [FUNCT_W-1:0]       out_funct,
  output logic [IMM_W-1:0]         out_imm,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int ENTRY_W = PC_W + INSTR_W;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] head_s;
  logic [INSTR_W-1:0] head_instr_s;

  // in_ready comes from registered state only, keeping out_ready off that path.
  assign in_ready     = ~full_s;
  assign out_valid    = ~empty_s;
  assign push_s       = in_valid & ~full_s & ~flush;
  assign pop_s        = ~empty_s & out_ready & ~flush;
  assign head_instr_s = head_s[INSTR_W-1:0];

  if_id_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data ({in_pc, in_instr}),
    .rd_data (head_s),
    .count   (occupancy),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Head fields, forced to zero when empty so decode sees a NOP bubble.
  always_comb begin
    out_pc     = '0;
    out_instr  = '0;
    out_opcode = '0;
    out_rs     = '0;
    out_rt     = '0;
    out_rd     = '0;
    out_shamt  = '0;
    out_funct  = '0;
    out_imm    = '0;
    if (!empty_s) begin
      out_pc     = head_s[ENTRY_W-1:INSTR_W];
      out_instr  = head_instr_s;
      out_opcode = head_instr_s[OPC_MSB -: OPC_W];
      out_rs     = head_instr_s[RS_MSB -: REG_W];
      out_rt     = head_instr_s[RT_MSB -: REG_W];
      out_rd     = head_instr_s[RD_MSB -: REG_W];
      out_shamt  = head_instr_s[SHAMT_MSB -: REG_W];
      out_funct  = head_instr_s[FUNCT_W-1:0];
      out_imm    = head_instr_s[IMM_W-1:0];
    end else begin
      out_pc     = '0;
      out_instr  = '0;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_if_id_buffer;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] model_q[$];
  logic [31:0] pc_cnt = 32'h0040_0000;
  bit seen_flushed = 1'b0;

  if_id_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt),
    .out_funct  (out_funct),
    .out_imm    (out_imm),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_instr == 32'h1000_FFFF) seen_flushed = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Compare every output against the model's current queue contents.
  task automatic compare_all(input string ph);
    logic [31:0] ei;
    logic [31:0] ep;
    bit ne;
    ne = (model_q.size() != 0);
    ei = ne ? model_q[0][31:0]  : 32'h0;
    ep = ne ? model_q[0][63:32] : 32'h0;
    check({ph, ":out_valid"}, 64'(out_valid), 64'(ne));
    check({ph, ":in_ready"},  64'(in_ready),  64'(model_q.size() != DEPTH));
    check({ph, ":occupancy"}, 64'(occupancy), 64'(model_q.size()));
    check({ph, ":out_pc"},    64'(out_pc),    64'(ep));
    check({ph, ":out_instr"}, 64'(out_instr), 64'(ei));
    check({ph, ":opcode"},    64'(out_opcode), 64'(ei / 32'd67108864));
    check({ph, ":rs"},        64'(out_rs),    64'((ei / 32'd2097152) % 32'd32));
    check({ph, ":rt"},        64'(out_rt),    64'((ei / 32'd65536) % 32'd32));
    check({ph, ":rd"},        64'(out_rd),    64'((ei / 32'd2048) % 32'd32));
    check({ph, ":shamt"},     64'(out_shamt), 64'((ei / 32'd64) % 32'd32));
    check({ph, ":funct"},     64'(out_funct), 64'(ei % 32'd64));
    check({ph, ":imm"},       64'(out_imm),   64'(ei % 32'd65536));
  endtask

  // One clock cycle: drive, check at negedge, advance model, return at posedge+1.
  task automatic cycle(input string ph, input logic v, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    bit room;
    in_valid  = v;
    in_pc     = pc_cnt;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    compare_all(ph);
    room = (model_q.size() != DEPTH);
    if (fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0 && ordy) void'(model_q.pop_front());
      if (v && room) model_q.push_back({pc_cnt, ins});
    end
    if (v) pc_cnt = pc_cnt + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_instr  = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    compare_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ori $t0,$t0,0xFFFF through and out
    cycle("ori_push", 1'b1, 32'h3508_FFFF, 1'b1, 1'b0);
    check("ori_opcode", 64'(out_opcode), 64'h0D);
    check("ori_rs",     64'(out_rs),     64'd8);
    check("ori_rt",     64'(out_rt),     64'd8);
    check("ori_imm",    64'(out_imm),    64'hFFFF);
    check("ori_pc",     64'(out_pc),     64'h0040_0000);
    cycle("ori_pop", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("ori_empty", 1'b0, 32'h0, 1'b1, 1'b0);

    // Fill while stalled, attempt a third beat, then drain in order
    cycle("full_a", 1'b1, 32'h2109_FFFC, 1'b0, 1'b0);
    cycle("full_b", 1'b1, 32'h8D2A_0004, 1'b0, 1'b0);
    check("full_occ", 64'(occupancy), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    cycle("full_c", 1'b1, 32'hAD2A_0008, 1'b0, 1'b0);
    check("full_head_held", 64'(out_instr), 64'h2109_FFFC);
    for (int i = 0; i < 3; i++) cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Steady state at occupancy 1 with push+pop every cycle (pointer wrap)
    cycle("ss_prime", 1'b1, 32'h2000_0100, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cycle("ss", 1'b1, 32'h2000_0100 + 32'(i), 1'b1, 1'b0);
      check("ss_occ", 64'(occupancy), 64'd1);
      check("ss_head", 64'(out_instr), 64'(32'h2000_0100 + 32'(i)));
    end
    cycle("ss_drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a full buffer and a beat offered in the same cycle
    cycle("fl_a", 1'b1, 32'h1111_0001, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 32'h1111_0002, 1'b0, 1'b0);
    cycle("fl_go", 1'b1, 32'h1000_FFFF, 1'b1, 1'b1);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_occ",   64'(occupancy), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    cycle("fl_after", 1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_never_out", 64'(seen_flushed), 64'd0);

    // R-type add $t0,$t1,$t2
    cycle("rtype", 1'b1, 32'h012A_4020, 1'b0, 1'b0);
    check("rt_opcode", 64'(out_opcode), 64'h00);
    check("rt_rs",     64'(out_rs),     64'd9);
    check("rt_rt",     64'(out_rt),     64'd10);
    check("rt_rd",     64'(out_rd),     64'd8);
    check("rt_shamt",  64'(out_shamt),  64'd0);
    check("rt_funct",  64'(out_funct),  64'h20);

    // Asynchronous reset mid-cycle with two entries held
    cycle("ar_b", 1'b1, 32'h2222_0002, 1'b0, 1'b0);
    check("ar_occ_before", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    compare_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pc_cnt = 32'h0040_0000;
    cycle("re_ori", 1'b1, 32'h3508_FFFF, 1'b1, 1'b0);
    check("re_opcode", 64'(out_opcode), 64'h0D);
    check("re_imm",    64'(out_imm),    64'hFFFF);
    cycle("re_pop", 1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end
    cycle("final", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
